// File: rtl/speed_window_sequencer_pkg.sv
// Shared types and constants for the sliding-window speed sequencer.
package speed_window_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned MIN_PERIOD    = 4;

endpackage

// File: rtl/speed_window_sequencer_prescaler.sv
// Sub-window prescaler: counts 0..per_q-1, flags terminal count, reloads the
// clamped period at every boundary and continuously while stopped.
module sub_period_prescaler
  import speed_window_sequencer_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [PERIOD_WIDTH-1:0] sub_period,
  output logic                    tc
);

  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] per_q, per_d;
  logic [PERIOD_WIDTH-1:0] per_clamped;

  always_comb begin
    per_clamped = (sub_period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : sub_period;
    tc          = run && (cnt_q == per_q - 1'b1);
    cnt_d       = cnt_q + 1'b1;
    per_d       = per_q;
    // Reloading every stopped cycle makes the value taken on the start edge the live one.
    if (!run || tc) begin
      cnt_d = '0;
      per_d = per_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      per_q <= PERIOD_WIDTH'(MIN_PERIOD);
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/speed_window_sequencer.sv
// Steps the pulse counter's SEL once per sub-window and publishes the settled
// full-window SUM as SPEED with a one-cycle valid strobe.
module speed_window_sequencer
  import speed_window_sequencer_pkg::*;
#(
  parameter int unsigned LOG2_N_SUB_CTRS = 4,
  parameter int unsigned PERIOD_WIDTH    = 24,
  parameter int unsigned SUM_WIDTH       = 16
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic                       EN,
  input  logic [PERIOD_WIDTH-1:0]    SUB_PERIOD,
  input  logic [SUM_WIDTH-1:0]       SUM_IN,
  output logic [LOG2_N_SUB_CTRS-1:0] SEL,
  output logic                       SUB_TICK,
  output logic [SUM_WIDTH-1:0]       SPEED,
  output logic                       SPEED_VALID,
  output logic                       FILLED
);

  localparam int unsigned          FILL_W = LOG2_N_SUB_CTRS + 1;
  localparam logic [FILL_W-1:0]    N_SUB  = FILL_W'(1 << LOG2_N_SUB_CTRS);

  state_e                       state_q, state_d;
  logic [LOG2_N_SUB_CTRS-1:0]   sel_q, sel_d;
  logic [FILL_W-1:0]            fill_q, fill_d;
  logic [SETTLE_CYCLES-1:0]     settle_q, settle_d;
  logic [SUM_WIDTH-1:0]         speed_q, speed_d;
  logic                         valid_q, valid_d;
  logic                         tick_q, tick_d;
  logic                         filled_q, filled_d;
  logic                         running;
  logic                         boundary;
  logic                         last_fill;
  logic                         sample_start;

  assign running = (state_q != IDLE);

  sub_period_prescaler #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_prescaler (
    .clk       (CLK),
    .rst_n     (RESETN),
    .run       (running),
    .sub_period(SUB_PERIOD),
    .tc        (boundary)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    fill_d       = fill_q;
    settle_d     = '0;
    speed_d      = speed_q;
    valid_d      = 1'b0;
    tick_d       = boundary;
    filled_d     = filled_q;
    last_fill    = (fill_q == N_SUB - 1'b1);
    sample_start = boundary && ((state_q == RUN) || last_fill);

    if (boundary) begin
      sel_d = sel_q + 1'b1;
      if (fill_q != N_SUB) fill_d = fill_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (EN) begin
          state_d = FILL;
          fill_d  = '0;
        end
      end
      FILL: begin
        if (boundary && last_fill) begin
          state_d  = RUN;
          filled_d = 1'b1;
        end
      end
      RUN:     ;
      default: state_d = IDLE;
    endcase

    if (running) begin
      settle_d = {settle_q[SETTLE_CYCLES-2:0], sample_start};
      if (settle_q[SETTLE_CYCLES-1] && (state_q == RUN)) begin
        speed_d = SUM_IN;
        valid_d = 1'b1;
      end
      // Disable still lets a coincident boundary advance SEL, but kills any pending sample.
      if (!EN) begin
        state_d  = IDLE;
        filled_d = 1'b0;
        settle_d = '0;
        valid_d  = 1'b0;
        speed_d  = speed_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      fill_q   <= '0;
      settle_q <= '0;
      speed_q  <= '0;
      valid_q  <= 1'b0;
      tick_q   <= 1'b0;
      filled_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      fill_q   <= fill_d;
      settle_q <= settle_d;
      speed_q  <= speed_d;
      valid_q  <= valid_d;
      tick_q   <= tick_d;
      filled_q <= filled_d;
    end
  end

  assign SEL         = sel_q;
  assign SUB_TICK    = tick_q;
  assign SPEED       = speed_q;
  assign SPEED_VALID = valid_q;
  assign FILLED      = filled_q;

endmodule

// File: tb/tb_speed_window_sequencer.sv
// Randomized scoreboard bench for speed_window_sequencer with N=4 sub-windows.
module tb_speed_window_sequencer;

  localparam int L2N = 2;
  localparam int NS  = 1 << L2N;
  localparam int PW  = 24;
  localparam int SW  = 16;

  logic           clk = 1'b0;
  logic           RESETN;
  logic           EN;
  logic [PW-1:0]  SUB_PERIOD;
  logic [SW-1:0]  SUM_IN;
  logic [L2N-1:0] SEL;
  logic           SUB_TICK;
  logic [SW-1:0]  SPEED;
  logic           SPEED_VALID;
  logic           FILLED;

  speed_window_sequencer #(
    .LOG2_N_SUB_CTRS(L2N),
    .PERIOD_WIDTH   (PW),
    .SUM_WIDTH      (SW)
  ) dut (
    .CLK        (clk),
    .RESETN     (RESETN),
    .EN         (EN),
    .SUB_PERIOD (SUB_PERIOD),
    .SUM_IN     (SUM_IN),
    .SEL        (SEL),
    .SUB_TICK   (SUB_TICK),
    .SPEED      (SPEED),
    .SPEED_VALID(SPEED_VALID),
    .FILLED     (FILLED)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int        tick_q[$];
  logic [SW-1:0] spd_q[$];

  // Reference model: window position/length, windows written, pending sample countdown.
  bit        m_active;
  int        m_pos, m_len, m_sel, m_fill, m_pending;
  bit        m_filled;
  logic [SW-1:0] m_speed;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int sp);
    return (sp < 4) ? 4 : sp;
  endfunction

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_len = 4; m_sel = 0; m_fill = 0;
    m_pending = 0; m_filled = 0; m_speed = '0;
    tick_q.delete();
    spd_q.delete();
  endtask

  // Predicts the effect of the coming rising edge from the inputs now applied.
  task automatic model_step();
    bit bnd;
    if (!m_active) begin
      if (EN) begin
        m_active = 1; m_pos = 0; m_len = clamp(int'(SUB_PERIOD)); m_fill = 0;
      end
      return;
    end
    if (m_pending > 0) begin
      m_pending--;
      if (m_pending == 0 && EN) begin
        m_speed = SUM_IN;
        spd_q.push_back(SUM_IN);
      end
    end
    bnd = (m_pos == m_len - 1);
    if (bnd) begin
      m_sel = (m_sel + 1) % NS;
      tick_q.push_back(m_sel);
      m_pos = 0;
      m_len = clamp(int'(SUB_PERIOD));
      if (m_fill < NS) m_fill++;
      if (m_fill == NS && EN) begin
        m_filled  = 1;
        m_pending = 2;
      end
    end else begin
      m_pos++;
    end
    if (!EN) begin
      m_active = 0; m_filled = 0; m_pending = 0;
    end
  endtask

  task automatic drive(input bit en, input int sp, input bit fixed_sum);
    @(negedge clk);
    RESETN     = 1'b1;
    EN         = en;
    SUB_PERIOD = PW'(sp);
    SUM_IN     = fixed_sum ? 16'h00A5 : SW'($urandom);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    RESETN = 1'b0;
    model_reset();
    #1;
    check("async_rst_sel", SEL, 0);
    check("async_rst_tick", SUB_TICK, 0);
    check("async_rst_speed", SPEED, 0);
    check("async_rst_valid", SPEED_VALID, 0);
    check("async_rst_filled", FILLED, 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares state every cycle and pops expected events when presented.
  initial begin
    int e;
    logic [SW-1:0] s;
    forever begin
      @(posedge clk);
      #1;
      check("sel", SEL, m_sel);
      check("filled", FILLED, m_filled);
      check("speed_hold", SPEED, m_speed);
      if (SUB_TICK || tick_q.size() != 0) begin
        if (tick_q.size() == 0) check("tick_unexpected", SUB_TICK, 0);
        else begin
          e = tick_q.pop_front();
          check("tick_present", SUB_TICK, 1);
          check("tick_sel", SEL, e);
        end
      end
      if (SPEED_VALID || spd_q.size() != 0) begin
        if (spd_q.size() == 0) check("valid_unexpected", SPEED_VALID, 0);
        else begin
          s = spd_q.pop_front();
          check("valid_present", SPEED_VALID, 1);
          check("speed_value", SPEED, s);
          check("valid_while_filled", FILLED, 1);
        end
      end
    end
  end

  initial begin
    int guard;
    bit en_r;
    int sp_r;
    RESETN = 1'b0; EN = 1'b0; SUB_PERIOD = PW'(10); SUM_IN = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Basic fill and run with a constant sum.
    repeat (90) drive(1, 10, 1);

    // Mid-window period change, then clamp of a tiny period.
    guard = 0;
    while (m_pos != 3 && guard < 50) begin drive(1, 10, 0); guard++; end
    check("wait_midwindow", guard < 50, 1);
    repeat (100) drive(1, 20, 0);
    repeat (40) drive(1, 1, 0);

    // Disable at SEL=2 one cycle before a sample, then re-enable.
    guard = 0;
    while (!(m_sel == 2 && m_pending == 1 && m_filled) && guard < 200) begin
      drive(1, 10, 0); guard++;
    end
    check("wait_pre_sample", guard < 200, 1);
    repeat (5) drive(0, 10, 0);
    repeat (80) drive(1, 10, 0);

    // Random enable/period traffic.
    en_r = 1; sp_r = 6;
    repeat (600) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      if ($urandom_range(0, 14) == 0) sp_r = int'($urandom_range(0, 14));
      drive(en_r, sp_r, 0);
    end

    // Async reset mid-window at SEL=3, then restart.
    guard = 0;
    while (!(m_sel == 3 && m_pos == 4) && guard < 200) begin drive(1, 10, 0); guard++; end
    check("wait_sel3", guard < 200, 1);
    do_reset();
    repeat (70) drive(1, 10, 0);

    @(posedge clk);
    #2;
    check("ticks_drained", tick_q.size(), 0);
    check("samples_drained", spd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
